// File: rtl/td4_pkg.sv
// Shared types and sizes for the TD4 writable program store.
// The loader's optional checksum (TD4_LOADER_CHECKSUM_EN) needs nothing from this package.
package td4_pkg;

  localparam int TD4_WORD_W = 8;
  localparam int TD4_ADDR_W = 4;
  localparam int TD4_DEPTH  = 16;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } td4_state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Byte-stream write channel into the TD4 program loader.
// The source of the program image drives valid/data, and the loader answers with ready.
interface td4_prog_loader_if;
  import td4_pkg::*;

  logic                  wr_valid;
  logic [TD4_WORD_W-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 instruction register file with one synchronous write port and a combinational read port.
// A synchronous clear zeroes every word, and a read of the word being written returns the old value.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [TD4_ADDR_W-1:0] wr_addr,
  input  logic [TD4_WORD_W-1:0] wr_data,
  input  logic [TD4_ADDR_W-1:0] rd_addr,
  output logic [TD4_WORD_W-1:0] rd_data
);

  logic [TD4_WORD_W-1:0] mem [TD4_DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < TD4_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/td4_prog_loader.sv
// Writable program store for the TD4 core: loads a 16-byte image, then releases the core's reset.
// Defining TD4_LOADER_CHECKSUM_EN adds a trailing checksum byte and a sticky err flag.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int RUN_DELAY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  td4_prog_loader_if.slave      wr,
  input  logic [TD4_ADDR_W-1:0] addr,
  output logic [TD4_WORD_W-1:0] data,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  td4_state_t            state, next_state;
  logic [TD4_ADDR_W-1:0] ptr;
  logic [3:0]            delay_cnt;
  logic                  accept;
  logic                  mem_we;

  assign accept     = (state == LOAD) && wr.wr_valid;
  assign wr.wr_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == RELEASE);

`ifdef TD4_LOADER_CHECKSUM_EN
  logic                  cks_phase;
  logic [TD4_WORD_W-1:0] sum;
  logic [TD4_WORD_W-1:0] sum_next;
  logic                  cks_ok;
  logic                  err_q;

  assign sum_next = sum + wr.wr_data;
  assign cks_ok   = (sum_next == '0);
  assign mem_we   = accept && !cks_phase;
  assign err      = err_q;
`else
  assign mem_we   = accept;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state <= HALT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HALT:    if (load_start) next_state = LOAD;
`ifdef TD4_LOADER_CHECKSUM_EN
      LOAD:    if (accept && cks_phase) next_state = cks_ok ? RELEASE : HALT;
`else
      LOAD:    if (accept && ptr == 4'(TD4_DEPTH - 1)) next_state = RELEASE;
`endif
      RELEASE: if (delay_cnt == 4'd1) next_state = RUN;
      RUN:     if (load_start) next_state = LOAD;
      default: next_state = HALT;
    endcase
  end

  // core_reset and done follow next_state so they switch on the same edge as the state does.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr        <= '0;
      delay_cnt  <= '0;
      core_reset <= 1'b0;
      done       <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
      cks_phase  <= 1'b0;
      sum        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      core_reset <= (next_state == RUN);
      done       <= (next_state == RUN) && (state != RUN);

      if (next_state == LOAD && state != LOAD) begin
        ptr       <= '0;
`ifdef TD4_LOADER_CHECKSUM_EN
        cks_phase <= 1'b0;
        sum       <= '0;
        err_q     <= 1'b0;
`endif
      end else if (accept) begin
`ifdef TD4_LOADER_CHECKSUM_EN
        if (cks_phase) begin
          cks_phase <= 1'b0;
          if (!cks_ok) err_q <= 1'b1;
        end else begin
          ptr <= ptr + 4'd1;
          sum <= sum_next;
          if (ptr == 4'(TD4_DEPTH - 1)) cks_phase <= 1'b1;
        end
`else
        ptr <= ptr + 4'd1;
`endif
      end

      if (next_state == RELEASE && state != RELEASE) delay_cnt <= 4'(RUN_DELAY);
      else if (state == RELEASE)                      delay_cnt <= delay_cnt - 4'd1;
    end
  end

  td4_prog_mem u_mem (
    .clock   (clock),
    .clear   (!reset),
    .wr_en   (mem_we),
    .wr_addr (ptr),
    .wr_data (wr.wr_data),
    .rd_addr (addr),
    .rd_data (data)
  );

endmodule

// File: tb/tb_td4_prog_loader.sv
// Scoreboard bench for td4_prog_loader: the stimulus queues expected responses, and a negedge monitor checks them.
// It follows TD4_LOADER_CHECKSUM_EN so that the expected image length and the checksum outcome match the build.
module tb_td4_prog_loader;
  import td4_pkg::*;

  localparam int RUN_DELAY = 2;
`ifdef TD4_LOADER_CHECKSUM_EN
  localparam int NBYTES = 17;
  localparam bit CKS    = 1'b1;
`else
  localparam int NBYTES = 16;
  localparam bit CKS    = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] data;
  logic       core_reset, busy, done, err;

  td4_prog_loader_if lif();

  td4_prog_loader #(.RUN_DELAY(RUN_DELAY)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .wr         (lif),
    .addr       (addr),
    .data       (data),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       core_reset;
    logic       wr_ready;
    logic       busy;
    logic       err;
  } probe_t;

  probe_t     probe_q[$];
  int         done_q[$];
  int         edge_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  logic       probe = 1'b0;

  // Reference model: the memory image plus a coarse phase (0 halted, 1 loading, 2 running).
  logic [7:0] img [17];
  logic [7:0] model_mem [16];
  int         phase = 0;
  bit         model_err = 1'b0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compareField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h edge=%0d", name, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clock) begin
    probe_t e;
    int     exp_edge;
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        compareField("done_unexpected", 1, 0);
      end else begin
        exp_edge = done_q.pop_front();
        compareField("done_edge", edge_cnt, exp_edge);
      end
    end
    if (probe) begin
      if (probe_q.size() == 0) begin
        compareField("probe_queue_empty", 1, 0);
      end else begin
        e = probe_q.pop_front();
        compareField($sformatf("data[%0d]", addr), int'(data), int'(e.data));
        compareField("core_reset", int'(core_reset), int'(e.core_reset));
        compareField("wr_ready", int'(lif.wr_ready), int'(e.wr_ready));
        compareField("busy", int'(busy), int'(e.busy));
        compareField("err", int'(err), int'(e.err));
      end
    end
  end

  task automatic checkOutput(input int a);
    probe_t e;
    addr = 4'(a);
    probe = 1'b1;
    e.data       = model_mem[a];
    e.core_reset = (phase == 2);
    e.wr_ready   = (phase == 1);
    e.busy       = (phase == 1);
    e.err        = model_err;
    probe_q.push_back(e);
    tick();
    probe = 1'b0;
  endtask

  task automatic checkAll();
    for (int a = 0; a < 16; a++) checkOutput(a);
  endtask

  task automatic clearModel();
    for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
    phase = 0;
    model_err = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    load_start = 1'b0;
    lif.wr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    clearModel();
  endtask

  task automatic startLoad();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    phase = 1;
    model_err = 1'b0;
  endtask

  task automatic fillChecksum(input bit good);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 16; k++) s += img[k];
    img[16] = (8'h00 - s) + (good ? 8'h00 : 8'h01);
  endtask

  task automatic randomImage();
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    fillChecksum(1'b1);
  endtask

  // mode 0: back-to-back; 1: valid on every other cycle; 2: random gaps with stray load_start pulses.
  task automatic applyStimulus(input int mode, input int nbytes);
    int         i;
    int         cyc;
    bit         gap;
    logic [7:0] s;
    i = 0;
    cyc = 0;
    while (i < nbytes) begin
      case (mode)
        1:       gap = ((cyc % 2) == 1);
        2:       gap = ($urandom_range(0, 2) == 0);
        default: gap = 1'b0;
      endcase
      if (gap) begin
        lif.wr_valid = 1'b0;
        lif.wr_data  = 8'($urandom);
        load_start   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        lif.wr_valid = 1'b1;
        lif.wr_data  = img[i];
        load_start   = 1'b0;
        if (i < 16) model_mem[i] = img[i];
        i++;
        if (i == NBYTES) begin
          s = 8'h00;
          for (int k = 0; k < NBYTES; k++) s += img[k];
          if (!CKS || s == 8'h00) begin
            done_q.push_back(edge_cnt + 1 + RUN_DELAY);
            phase = 2;
          end else begin
            phase = 0;
            model_err = 1'b1;
          end
        end
      end
      tick();
      cyc++;
    end
    lif.wr_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic strayWrites(input int n);
    for (int k = 0; k < n; k++) begin
      lif.wr_valid = 1'b1;
      lif.wr_data  = 8'($urandom);
      tick();
    end
    lif.wr_valid = 1'b0;
  endtask

  initial begin
    lif.wr_valid = 1'b0;
    lif.wr_data  = 8'h00;
    clearModel();
    doReset();
    $display("[TB] reset state");
    checkAll();

    reset = 1'b0;
    load_start = 1'b1;
    tick();
    reset = 1'b1;
    load_start = 1'b0;
    checkOutput(0);
    strayWrites(3);
    checkOutput(1);

    $display("[TB] directed back-to-back load");
    img = '{8'hB7, 8'h01, 8'hE1, 8'h02, 8'hF3, 8'h04, 8'h95, 8'h06,
            8'hA7, 8'h08, 8'hC9, 8'h0A, 8'hDB, 8'h0C, 8'hEE, 8'hFF, 8'h00};
    fillChecksum(1'b1);
    startLoad();
    applyStimulus(0, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();

    $display("[TB] toggling-valid load of the same image");
    startLoad();
    checkOutput(0);
    applyStimulus(1, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();
    strayWrites(4);
    for (int a = 0; a < 4; a++) checkOutput(a);

    $display("[TB] random images with gaps");
    for (int r = 0; r < 4; r++) begin
      randomImage();
      startLoad();
      checkOutput(r);
      applyStimulus(2, NBYTES);
      repeat (RUN_DELAY) tick();
      checkAll();
    end

    reset = 1'b0;
    load_start = 1'b1;
    tick();
    reset = 1'b1;
    load_start = 1'b0;
    clearModel();
    checkOutput(0);
    checkOutput(9);

    $display("[TB] reset after seven bytes");
    randomImage();
    startLoad();
    applyStimulus(0, 7);
    doReset();
    checkAll();
    randomImage();
    startLoad();
    applyStimulus(2, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();

`ifdef TD4_LOADER_CHECKSUM_EN
    $display("[TB] checksum pass and fail");
    for (int k = 0; k < 16; k++) img[k] = 8'h01;
    img[16] = 8'hF0;
    startLoad();
    applyStimulus(0, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();
    img[16] = 8'hF1;
    startLoad();
    applyStimulus(0, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();
    randomImage();
    startLoad();
    checkOutput(0);
    applyStimulus(1, NBYTES);
    repeat (RUN_DELAY) tick();
    checkAll();
`endif

    repeat (4) tick();
    compareField("done_q_drained", done_q.size(), 0);
    compareField("probe_q_drained", probe_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Writable program store for the TD4 CPU, sitting directly upstream of the core: it replaces the fixed 16×8 instruction ROM.
- Accepts a program image as a byte stream over a valid/ready handshake and writes it into a 16-entry instruction memory.
- Holds the core in reset while loading, then releases it to execute from address 0.
- The core's instruction pointer reads the memory combinationally, exactly as it does today.

## Interface
- `RUN_DELAY`, default 2: cycles the core is kept in reset after the last byte is accepted (legal range 1..15).
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `load_start`  in  1  single-cycle request to begin loading a new program.
- `wr_valid`  in  1  byte present on `wr_data`.
- `wr_data`  in  8  program byte, opcode in [7:4], immediate in [3:0].
- `wr_ready`  out  1  loader accepts a byte this cycle.
- `addr`  in  4  instruction pointer from the core.
- `data`  out  8  instruction at `addr`, combinational.
- `core_reset`  out  1  active-low reset to the core; registered.
- `busy`  out  1  high in LOAD or RELEASE.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `err`  out  1  sticky checksum failure flag.

## Operation
- States: HALT, LOAD, RELEASE, RUN.
- **Reset** (`reset`=0 at an edge):
  - State goes to HALT; all 16 words clear to 8'h00; write pointer clears to 0.
  - `core_reset`=0, `wr_ready`=0, `busy`=0, `done`=0, `err`=0.
- **HALT:** the core is held in reset. `load_start` moves to LOAD.
- **LOAD:**
  - Entry clears the write pointer and `err`. `core_reset`=0 and `wr_ready`=1.
  - A byte is accepted on each cycle where `wr_valid` and `wr_ready` are both high: it is written to mem[ptr], then ptr increments.
  - Acceptance of the byte at ptr=15 moves to RELEASE. The pointer wraps to 0 and is unused after that.
  - `load_start` is ignored while in LOAD.
- **RELEASE:**
  - Entry loads a delay counter with RUN_DELAY, which decrements every cycle.
  - Moves to RUN when the counter reaches 1. `wr_ready`=0.
- **RUN:**
  - `core_reset`=1, so the core starts at ip=0.
  - `load_start` returns to LOAD; `core_reset` drops on the same edge the state changes.
- **Read path:**
  - `data` = mem[`addr`] at all times, including during LOAD.
  - A read and a write to the same address in the same cycle return the old value.
- `wr_valid` outside LOAD is ignored and writes nothing.

## Timing
- `wr_ready` and `busy` decode the registered state, so they change only after an edge.
- Last byte accepted at edge N:
  - State is RELEASE from edge N.
  - RUN and `core_reset`=1 from edge N+RUN_DELAY.
  - `done` is high for exactly the first RUN cycle.
- `load_start` in RUN at edge M: `core_reset`=0 and `wr_ready`=1 from edge M.
- `load_start` asserted together with a reset edge: reset wins.
- Reset mid-load: the partial image is discarded and memory clears to zero.
- Maximum throughput is one byte per cycle, so a full load takes 16 cycles plus RUN_DELAY.

## Configuration
- Controlled by the macro `TD4_LOADER_CHECKSUM_EN`.
- **Defined:**
  - LOAD accepts a 17th byte, the checksum. It is not written to memory.
  - If (sum of the 16 bytes + checksum) mod 256 = 0, the loader moves to RELEASE.
  - Otherwise it moves to HALT with `err`=1 and the core stays in reset. The already-written memory is retained but not executed.
- **Undefined:** the load is 16 bytes, no checksum is kept, and `err` is tied to 0.

## Structure
- Package `td4_pkg` holds:
  - the state enum (HALT/LOAD/RELEASE/RUN);
  - `TD4_WORD_W`=8, `TD4_ADDR_W`=4, `TD4_DEPTH`=16.
- Sub-module `td4_prog_mem`: 16×8 register file with one synchronous write port, one combinational read port and a synchronous clear. The FSM, pointer, delay counter and checksum accumulator stay in the top module.

## Test plan
- Reset, then sample outputs → `core_reset`=0, `wr_ready`=0, `data`=8'h00 for every `addr`.
- `load_start`, then 16 bytes back-to-back (8'hB7, 8'h01, 8'hE1, …, 8'hFF), RUN_DELAY=2 → `done` pulse 2 cycles after the last accept; `data` at addr 0 = 8'hB7 and at addr 15 = 8'hFF.
- Load with `wr_valid` toggling every other cycle → only handshaked bytes are written; the image is identical to the back-to-back case.
- `reset` asserted after 7 bytes → HALT, memory all 8'h00; a subsequent full load succeeds.
- In RUN, assert `load_start` → `core_reset` falls on the same edge; new image takes effect; `load_start` pulses during LOAD have no effect.
- With `TD4_LOADER_CHECKSUM_EN`:
  - 16 bytes of 8'h01 plus checksum 8'hF0 → RUN.
  - Checksum 8'hF1 → HALT, `err`=1, `core_reset` stays 0.
